spi_clk_seq: RTL

Serial-clock and transfer sequencer for the SPI master. It sits directly upstream of the shift register. It takes a start request from the APB register block, drives the chip selects with programmable lead and trail delays, and generates the divided serial clock `s_clk`. It also produces the one-cycle `pos_edge` / `neg_edge` strobes and the `go` pulse that the shift register consumes. Transfer termination uses the shift register's `last` flag.

---
 rtl/spi_clk_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spi_clk_seq.sv
// spi_clk_seq: chip-select and serial-clock sequencer for the SPI master.
// Runs lead delay, divided s_clk generation and trail delay around one transfer.
// Emits go/pos_edge/neg_edge strobes for the shift register, which ends the
// transfer through its last flag.
//
// state | meaning
// IDLE  | waiting for start; s_clk follows live cpol
// LEAD  | slave selected, counting lead delay before first clock activity
// RUN   | dividing clk into s_clk phases and issuing strobes
// TRAIL | slave still selected, counting trail delay before done
module spi_clk_seq #(
    parameter int DIV_W = 16,
    parameter int DLY_W = 8,
    parameter int SS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divider,
    input  logic             cpol,
    input  logic [SS_W-1:0]  ss_sel,
    input  logic             ss_auto,
    input  logic [DLY_W-1:0] lead_dly,
    input  logic [DLY_W-1:0] trail_dly,
    input  logic             last,
    output logic             go,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             s_clk,
    output logic [SS_W-1:0]  ss_n,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LEAD, RUN, TRAIL} state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DLY_W-1:0] dly;
    logic [DLY_W-1:0] trail_q;
    logic             ph;
    logic             cpol_q;
    logic             auto_q;
    logic [SS_W-1:0]  sel_q;
    logic [SS_W-1:0]  ss_act;
    logic [SS_W-1:0]  ss_idle;
    logic             cnt_zero;
    logic             dly_zero;

    // Strobes are decodes of registered state so they line up with the
    // cycle in which the counter reaches zero.
    assign cnt_zero = (cnt == '0);
    assign dly_zero = (dly == '0);
    assign busy     = (state != IDLE);
    assign go       = (state == LEAD)  && dly_zero;
    assign done     = (state == TRAIL) && dly_zero;
    assign pos_edge = (state == RUN) && cnt_zero && !ph;
    assign neg_edge = (state == RUN) && cnt_zero && ph;

    // Select patterns for an active transfer and for idle; manual mode follows live ss_sel.
    assign ss_act  = auto_q  ? ~sel_q : ~ss_sel;
    assign ss_idle = ss_auto ? '1     : ~ss_sel;

    // Sequencer state, counters, latched configuration and registered pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= '0;
            dly     <= '0;
            trail_q <= '0;
            ph      <= 1'b0;
            cpol_q  <= 1'b0;
            auto_q  <= 1'b0;
            sel_q   <= '0;
            s_clk   <= 1'b0;
            ss_n    <= '1;
        end else begin
            case (state)
                IDLE: begin
                    ph    <= 1'b0;
                    s_clk <= cpol;
                    ss_n  <= ss_idle;
                    if (start) begin
                        div_q   <= divider;
                        cpol_q  <= cpol;
                        sel_q   <= ss_sel;
                        auto_q  <= ss_auto;
                        trail_q <= trail_dly;
                        dly     <= lead_dly;
                        ss_n    <= ~ss_sel;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    s_clk <= cpol_q;
                    ss_n  <= ss_act;
                    if (dly_zero) begin
                        cnt   <= div_q;
                        state <= RUN;
                    end else begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                RUN: begin
                    ss_n  <= ss_act;
                    s_clk <= ph ^ cpol_q;
                    if (!cnt_zero) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        cnt <= div_q;
                        if (ph) begin
                            ph    <= 1'b0;
                            s_clk <= cpol_q;
                        end else if (!last) begin
                            ph    <= 1'b1;
                            s_clk <= ~cpol_q;
                        end else begin
                            // terminating strobe: no toggle, go count trail delay
                            dly   <= trail_q;
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (dly_zero) begin
                        s_clk <= cpol;
                        ss_n  <= ss_idle;
                        state <= IDLE;
                    end else begin
                        s_clk <= cpol_q;
                        ss_n  <= ss_act;
                        dly   <= dly - DLY_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
